// File: rtl/sr_run_ctrl_pkg.sv
// Shared types and default constants for the sr_cpu run/test sequencer.
package sr_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DONE,
    DUMP_ADDR,
    DUMP_WAIT
  } runState_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'b00,
    FAIL_TIMEOUT = 2'b01,
    FAIL_STALL   = 2'b10
  } failCode_e;

  localparam logic [4:0]  DEF_IO_REG = 5'd10;
  localparam logic [31:0] DEF_EXP0   = 32'h00213d05;
  localparam logic [31:0] DEF_EXP1   = 32'h1c8cfc00;

endpackage

// File: rtl/sr_stall_detect.sv
// Flags a halted CPU: the instruction address has held one value for
// STALL_LIMIT consecutive samples.
module sr_stall_detect #(
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        sample,
  input  logic [31:0] addr,
  output logic        stalled
);

  localparam int CW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  logic [31:0]   prevAddr;
  logic          havePrev;
  logic [CW-1:0] eqCnt;
  logic          same;

  // eqCnt holds the number of back-to-back equal samples seen so far, so the
  // current equal sample completes the window when it already reads LIMIT-2.
  assign same    = havePrev && (addr == prevAddr);
  assign stalled = same && (eqCnt == CW'(STALL_LIMIT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevAddr <= '0;
      havePrev <= 1'b0;
      eqCnt    <= '0;
    end else if (clear) begin
      havePrev <= 1'b0;
      eqCnt    <= '0;
    end else if (sample) begin
      prevAddr <= addr;
      havePrev <= 1'b1;
      if (!same)
        eqCnt <= '0;
      else if (eqCnt != CW'(STALL_LIMIT - 1))
        eqCnt <= eqCnt + 1'b1;
    end
  end

endmodule

// File: rtl/sr_run_ctrl.sv
// Run/test sequencer for sr_cpu: reset release, pass/timeout/stall detection
// and a valid/ready register dump through the debug read port.
module sr_run_ctrl
  import sr_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned STALL_LIMIT = 8,
  parameter logic [4:0]  IO_REG      = DEF_IO_REG,
  parameter logic [31:0] EXP0        = DEF_EXP0,
  parameter logic [31:0] EXP1        = DEF_EXP1,
  localparam int CNT_W = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dump_en,
  output logic             cpu_rst,
  output logic [4:0]       reg_addr,
  input  logic [31:0]      reg_data,
  input  logic [31:0]      im_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycles,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  input  logic             dump_ready
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  runState_e       state;
  logic [RC_W-1:0] rstCnt;
  logic            isMatch;
  logic            isTimeout;
  logic            stalled;

  assign isMatch   = (reg_data == EXP0) || (reg_data == EXP1);
  assign isTimeout = (cycles == CNT_W'(MAX_CYCLES - 1));

  // Held in clear outside RUN, so every run starts with no previous sample.
  sr_stall_detect #(
    .STALL_LIMIT(STALL_LIMIT)
  ) uStall (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != RUN),
    .sample (state == RUN),
    .addr   (im_addr),
    .stalled(stalled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rstCnt     <= '0;
      cpu_rst    <= 1'b1;
      reg_addr   <= IO_REG;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= FAIL_NONE;
      cycles     <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RESET;
            rstCnt    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FAIL_NONE;
            cycles    <= '0;
          end else if (dump_en && (state == DONE)) begin
            state    <= DUMP_ADDR;
            busy     <= 1'b1;
            dump_idx <= '0;
            reg_addr <= '0;
          end
        end
        RESET: begin
          if (rstCnt == RC_W'(RST_CYCLES - 1)) begin
            state    <= RUN;
            cpu_rst  <= 1'b0;
            reg_addr <= IO_REG;
          end else begin
            rstCnt <= rstCnt + 1'b1;
          end
        end
        // A match outranks timeout and stall decided on the same sample.
        RUN: begin
          if (cycles != CNT_W'(MAX_CYCLES))
            cycles <= cycles + 1'b1;
          if (isMatch || isTimeout || stalled) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_rst <= 1'b1;
            pass    <= isMatch;
            if (isMatch)
              fail_code <= FAIL_NONE;
            else if (isTimeout)
              fail_code <= FAIL_TIMEOUT;
            else
              fail_code <= FAIL_STALL;
          end
        end
        DUMP_ADDR: begin
          dump_data  <= reg_data;
          dump_valid <= 1'b1;
          state      <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_idx == 5'd31) begin
              dump_idx <= '0;
              reg_addr <= IO_REG;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              dump_idx <= dump_idx + 1'b1;
              reg_addr <= dump_idx + 1'b1;
              state    <= DUMP_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
